// File: rtl/fwd_hazard_unit.sv
// Forwarding-select, load-use stall and flush tracking for the pipelined CPU.
// Shadow EX/MEM/WB write flags keep forwarding decisions tied to real, unflushed writers.
module fwd_hazard_unit #(
   parameter int ZERO_REG = 31,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic             regwrite_id,
   input  logic             memtoreg_id,
   input  logic             uses_rn,
   input  logic             uses_rb,
   input  logic [4:0]       rn_read,
   input  logic [4:0]       regB_sel,
   input  logic [4:0]       rd_exe,
   input  logic [4:0]       rd_mem,
   input  logic [4:0]       rd_wb,
   input  logic             flush,
   output logic [1:0]       fwdr1,
   output logic [1:0]       fwdr2,
   output logic             stall,
   output logic             bubble,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [4:0] ZR = 5'(ZERO_REG);

   typedef enum logic {RUN, HOLD} state_t;

   state_t           state_q, state_d;
   logic             wr_ex_q, ld_ex_q, wr_mem_q, wr_wb_q;
   logic             wr_ex_d, ld_ex_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic             match_a, match_b, hazard;

   // A load in EX must not be forwarded from EX; its data only exists once it reaches MEM.
   function automatic logic [1:0] fwd_sel(
      input logic       used,
      input logic [4:0] src,
      input logic [4:0] re,
      input logic [4:0] rm,
      input logic [4:0] rw,
      input logic       wex,
      input logic       lex,
      input logic       wmem,
      input logic       wwb
   );
      if (!used || src == ZR)           return 2'b00;
      else if (src == re && wex && !lex) return 2'b01;
      else if (src == rm && wmem)       return 2'b10;
      else if (src == rw && wwb)        return 2'b11;
      else                              return 2'b00;
   endfunction

   assign fwdr1 = fwd_sel(uses_rn, rn_read, rd_exe, rd_mem, rd_wb,
                          wr_ex_q, ld_ex_q, wr_mem_q, wr_wb_q);
   assign fwdr2 = fwd_sel(uses_rb, regB_sel, rd_exe, rd_mem, rd_wb,
                          wr_ex_q, ld_ex_q, wr_mem_q, wr_wb_q);

   assign match_a = uses_rn && (rn_read == rd_exe);
   assign match_b = uses_rb && (regB_sel == rd_exe);
   assign hazard  = id_valid && ld_ex_q && wr_ex_q && (rd_exe != ZR) && (match_a || match_b);

   always_comb begin
      stall         = 1'b0;
      bubble        = 1'b0;
      state_d       = RUN;
      if (state_q == RUN && hazard) begin
         stall   = 1'b1;
         bubble  = 1'b1;
         state_d = HOLD;
      end
      // Flush kills the decode instruction outright, so there is nothing left to hold.
      if (flush) begin
         stall   = 1'b0;
         bubble  = 1'b1;
         state_d = RUN;
      end
      if (!reset) begin
         stall  = 1'b0;
         bubble = 1'b0;
      end
      wr_ex_d       = regwrite_id && id_valid && !bubble;
      ld_ex_d       = memtoreg_id && id_valid && !bubble;
      stall_count_d = stall_count_q;
      if (stall && stall_count_q != {CNT_W{1'b1}})
         stall_count_d = stall_count_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= RUN;
         wr_ex_q       <= 1'b0;
         ld_ex_q       <= 1'b0;
         wr_mem_q      <= 1'b0;
         wr_wb_q       <= 1'b0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         wr_ex_q       <= wr_ex_d;
         ld_ex_q       <= ld_ex_d;
         wr_mem_q      <= wr_ex_q;
         wr_wb_q       <= wr_mem_q;
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fwd_hazard_unit;
   localparam int CW = 4;

   logic          clk;
   logic          reset;
   logic          id_valid, regwrite_id, memtoreg_id, uses_rn, uses_rb, flush;
   logic [4:0]    rn_read, regB_sel, rd_exe, rd_mem, rd_wb;
   logic [1:0]    fwdr1, fwdr2;
   logic          stall, bubble;
   logic [CW-1:0] stall_count;

   typedef struct packed {
      logic [1:0]    f1;
      logic [1:0]    f2;
      logic          st;
      logic          bu;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    errors = 0;
   int    checks = 0;

   fwd_hazard_unit #(.ZERO_REG(31), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .regwrite_id(regwrite_id),
      .memtoreg_id(memtoreg_id), .uses_rn(uses_rn), .uses_rb(uses_rb),
      .rn_read(rn_read), .regB_sel(regB_sel), .rd_exe(rd_exe), .rd_mem(rd_mem),
      .rd_wb(rd_wb), .flush(flush), .fwdr1(fwdr1), .fwdr2(fwdr2), .stall(stall),
      .bubble(bubble), .stall_count(stall_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         exp_t  a;
         string n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         a = '{f1: fwdr1, f2: fwdr2, st: stall, bu: bubble, cnt: stall_count};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got f1=%b f2=%b stall=%b bubble=%b cnt=%0d, expected f1=%b f2=%b stall=%b bubble=%b cnt=%0d",
                     n, a.f1, a.f2, a.st, a.bu, a.cnt, e.f1, e.f2, e.st, e.bu, e.cnt);
         end
      end
   end

   task automatic drv(input logic v, input logic rw, input logic mr, input logic ur,
                      input logic ub, input logic [4:0] rn, input logic [4:0] rb,
                      input logic [4:0] re, input logic [4:0] rm, input logic [4:0] rwb,
                      input logic fl);
      @(posedge clk);
      #1;
      id_valid = v; regwrite_id = rw; memtoreg_id = mr; uses_rn = ur; uses_rb = ub;
      rn_read = rn; regB_sel = rb; rd_exe = re; rd_mem = rm; rd_wb = rwb; flush = fl;
   endtask

   task automatic expect_out(input string n, input logic [1:0] f1, input logic [1:0] f2,
                             input logic st, input logic bu, input int cnt);
      exp_q.push_back('{f1: f1, f2: f2, st: st, bu: bu, cnt: CW'(cnt)});
      name_q.push_back(n);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0);
   endtask

   initial begin
      reset = 1'b0;
      id_valid = 0; regwrite_id = 0; memtoreg_id = 0; uses_rn = 0; uses_rb = 0; flush = 0;
      rn_read = 0; regB_sel = 0; rd_exe = 0; rd_mem = 0; rd_wb = 0;

      repeat (2) @(posedge clk);
      #1;
      flush = 1'b1;
      expect_out("reset_state", 2'b00, 2'b00, 0, 0, 0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      reset = 1'b1;

      // back-to-back, two/three-ahead, same-index
      drv(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0);
      drv(1, 1, 0, 1, 1, 5'd1, 5'd3, 5'd1, 5'd0, 5'd0, 0);
      expect_out("back_to_back", 2'b01, 2'b00, 0, 0, 0);
      drv(1, 1, 0, 1, 0, 5'd5, 5'd5, 5'd5, 5'd5, 5'd7, 0);
      expect_out("ex_over_mem", 2'b01, 2'b00, 0, 0, 0);
      drv(1, 0, 0, 1, 1, 5'd5, 5'd7, 5'd9, 5'd5, 5'd7, 0);
      expect_out("mem_and_wb", 2'b10, 2'b11, 0, 0, 0);
      drv(0, 0, 0, 1, 1, 5'd7, 5'd7, 5'd7, 5'd3, 5'd7, 0);
      expect_out("same_index_wb", 2'b11, 2'b11, 0, 0, 0);
      idle(3);

      // load-use
      drv(1, 1, 1, 1, 0, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 0);
      expect_out("ldur_issue", 2'b00, 2'b00, 0, 0, 0);
      drv(1, 1, 0, 1, 1, 5'd4, 5'd4, 5'd4, 5'd0, 5'd0, 0);
      expect_out("load_use_stall", 2'b00, 2'b00, 1, 1, 0);
      drv(1, 1, 0, 1, 1, 5'd4, 5'd4, 5'd4, 5'd4, 5'd0, 0);
      expect_out("load_use_hold", 2'b10, 2'b10, 0, 0, 1);
      drv(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0);
      expect_out("after_hold", 2'b00, 2'b00, 0, 0, 1);
      idle(3);

      // zero register
      drv(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0);
      drv(1, 0, 0, 1, 1, 5'd31, 5'd2, 5'd31, 5'd0, 5'd0, 0);
      expect_out("zero_reg_load", 2'b00, 2'b00, 0, 0, 1);
      idle(3);

      // flush during hazard
      drv(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0);
      drv(1, 1, 0, 1, 0, 5'd8, 5'd0, 5'd8, 5'd0, 5'd0, 1);
      expect_out("flush_hazard", 2'b00, 2'b00, 0, 1, 1);
      drv(1, 0, 0, 1, 1, 5'd9, 5'd8, 5'd9, 5'd8, 5'd0, 0);
      expect_out("after_flush", 2'b00, 2'b10, 0, 0, 1);
      idle(3);

      // async reset mid-HOLD
      drv(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0);
      drv(1, 1, 0, 1, 0, 5'd4, 5'd0, 5'd4, 5'd0, 5'd0, 0);
      expect_out("pre_reset_stall", 2'b00, 2'b00, 1, 1, 1);
      drv(1, 1, 0, 1, 1, 5'd4, 5'd4, 5'd4, 5'd4, 5'd0, 1);
      #2;
      reset = 1'b0;
      expect_out("reset_mid_hold", 2'b00, 2'b00, 0, 0, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      drv(1, 1, 0, 1, 1, 5'd4, 5'd4, 5'd4, 5'd4, 5'd0, 0);
      expect_out("post_reset_run", 2'b00, 2'b00, 0, 0, 0);
      idle(3);

      // counter saturation (CW-bit counter in this bench)
      for (int i = 0; i < 17; i++) begin
         drv(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0);
         drv(1, 1, 0, 1, 0, 5'd4, 5'd0, 5'd4, 5'd0, 5'd0, 0);
         expect_out($sformatf("sat_stall_%0d", i), 2'b00, 2'b00, 1, 1, (i > 15) ? 15 : i);
         drv(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0);
      end
      drv(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0);
      expect_out("sat_final", 2'b00, 2'b00, 0, 0, 15);

      repeat (3) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
